range_counter_param: RTL and testbench
======================================

// Module: range_counter_param
// PURPOSE
//  Parametrised range counter: counts from a start bound to an end bound, up or down.
//  Runs one-shot (halt at end, raise done) or wrap (reload and continue).
//  Range, direction and mode are sampled at start. Gated by a count enable.
//  General sequencing/timebase primitive for counter-driven control blocks.
// PARAMETERS
//  WIDTH    8   bit width of count, lo, hi
//  WRAPW    8   bit width of wrap_cnt (saturating)
// PORTS
//  clk       in   1      single clock, all logic on posedge clk
//  rst       in   1      synchronous active-high reset
//  start     in   1      load range and begin counting (1-cycle pulse or level)
//  stop      in   1      abort run, return to IDLE, count held
//  en        in   1      count enable; 0 = hold
//  dir_down  in   1      0 = count lo->hi, 1 = count hi->lo (sampled at start)
//  mode_wrap in   1      0 = one-shot, 1 = wrap (sampled at start)
//  lo        in   WIDTH  lower bound, inclusive (sampled at start)
//  hi        in   WIDTH  upper bound, inclusive (sampled at start)
//  count     out  WIDTH  current count (registered)
//  busy      out  1      state == RUN
//  tc        out  1      terminal count: busy && count == end bound (combinational)
//  done      out  1      state == DONE (one-shot finished)
//  err       out  1      1-cycle pulse: start rejected because lo > hi
//  wrap_cnt  out  WRAPW  completed wraps since last start, saturates at all-ones
// BEHAVIOUR
//  Single clock; reset is synchronous and active-high (clk, rst).
//  Reset: state=IDLE, count=0, busy=0, done=0, err=0, wrap_cnt=0; tc=0 follows.
//  Latched regs: lo_q, hi_q, dir_q, wrap_q. begin = dir_q ? hi_q : lo_q; end = the other bound.
//  States: IDLE, RUN, DONE (2-bit encoded).
//  IDLE: start && lo<=hi -> latch inputs, count<=begin, wrap_cnt<=0, go RUN next edge.
//        start && lo>hi  -> err=1 for one cycle; state, count and latches unchanged.
//  RUN, en=0: count holds; tc still reflects count.
//  RUN, en=1, !tc: count <= count+1 (up) or count-1 (down); mod 2^WIDTH, no carry out.
//  RUN, en=1, tc, wrap_q=1: count<=begin, wrap_cnt+1 (saturating), stay RUN.
//  RUN, en=1, tc, wrap_q=0: go DONE, count holds end, done=1 next cycle.
//  DONE: count and done held until start (restart per IDLE rules) or rst.
//  start in RUN or DONE: restart exactly as from IDLE (err if lo>hi; on err the current
//    state and count are kept).
//  Priority, highest first: rst > stop > start > en/tc.
//  stop in RUN or DONE -> IDLE; count held; done=0; wrap_cnt held.
//  lo==hi: tc=1 on the first RUN cycle; one-shot completes on first en; wrap reloads same value.
//  Full range (lo=0, hi=2^WIDTH-1): no overflow; tc at bound, never arithmetic wrap.
//  Latency: start -> count=begin and busy=1 at next edge. Last en at end -> done=1 at next edge.
//  lo/hi/dir/mode changes during RUN have no effect until the next start.
// TESTING
//  T1: lo=5, hi=67, up, one-shot, en=1 from start: count 5..67 in 63 cycles, tc@67,
//      done=1 next edge, count holds 67 forever.
//  T2: lo=3, hi=6, down, wrap, en=1: count 6,5,4,3,6,5... wrap_cnt increments on each 3->6.
//      Force WRAPW=2 and verify saturation at 3.
//  T3: en toggled 1/0 each cycle, lo=0, hi=4, up, one-shot: count advances only on en=1
//      cycles; done after 5 enabled cycles.
//  T4: start with lo=9, hi=2: err pulses 1 cycle, state stays IDLE, count unchanged;
//      same stimulus during RUN keeps RUN and count.
//  T5: boundaries: lo=hi=7 gives tc=1 immediately; lo=0, hi=255, WIDTH=8 gives no wrap past 255;
//      start and stop same cycle gives IDLE.
//  T6: rst asserted mid-RUN (count=40) -> next edge all outputs at reset values; start restarts cleanly.

Source files
------------

// File: rtl/range_counter_param_if.sv
// Control/status bundle for range_counter_param. The master side drives the run
// request, the range and the enable; the slave (the counter) returns count and status.
interface range_counter_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WRAPW = 8
);

  // Requests toward the counter
  logic             start;
  logic             stop;
  logic             en;
  logic             dir_down;
  logic             mode_wrap;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  // Status from the counter
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic             err;
  logic [WRAPW-1:0] wrap_cnt;

  modport master (
    output start,
    output stop,
    output en,
    output dir_down,
    output mode_wrap,
    output lo,
    output hi,
    input  count,
    input  busy,
    input  tc,
    input  done,
    input  err,
    input  wrap_cnt
  );

  modport slave (
    input  start,
    input  stop,
    input  en,
    input  dir_down,
    input  mode_wrap,
    input  lo,
    input  hi,
    output count,
    output busy,
    output tc,
    output done,
    output err,
    output wrap_cnt
  );

endinterface

// File: rtl/range_counter_param.sv
// Parametrised range counter. Walks from a begin bound to an end bound (up or down),
// then either halts with done (one-shot) or reloads the begin bound (wrap). Range,
// direction and mode are captured when a run starts; later input changes are ignored
// until the next start.
module range_counter_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WRAPW = 8
) (
  input logic                  clk,
  input logic                  rst,
  range_counter_param_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             err_q, err_d;

  // Bounds of the latched run
  logic [WIDTH-1:0] begin_val;
  logic [WIDTH-1:0] end_val;
  logic             running;
  logic             at_end;

  // Bounds presented on the inputs, used only when a start is accepted
  logic             range_ok;
  logic [WIDTH-1:0] new_begin;
  logic             wrap_full;

  // Derive latched bounds, terminal count and start qualification
  always_comb begin
    begin_val = dir_q ? hi_q : lo_q;
    end_val   = dir_q ? lo_q : hi_q;
    running   = (state_q == StRun);
    at_end    = running && (count_q == end_val);
    range_ok  = (bus.lo <= bus.hi);
    new_begin = bus.dir_down ? bus.hi : bus.lo;
    wrap_full = &wrap_cnt_q;
  end

  // Next-state: stop beats start, start beats counting
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    dir_d      = dir_q;
    wrap_d     = wrap_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = 1'b0;

    if (bus.stop) begin
      // Abort: count and wrap count stay visible, done drops with the state change
      state_d = StIdle;
    end else if (bus.start) begin
      if (range_ok) begin
        lo_d       = bus.lo;
        hi_d       = bus.hi;
        dir_d      = bus.dir_down;
        wrap_d     = bus.mode_wrap;
        count_d    = new_begin;
        wrap_cnt_d = '0;
        state_d    = StRun;
      end else begin
        // Rejected start: flag it and leave the current run untouched
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StRun: begin
          if (bus.en) begin
            if (!at_end) begin
              // Never crosses a bound here, so plain modular step is safe
              count_d = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
            end else if (wrap_q) begin
              count_d = begin_val;
              if (!wrap_full) begin
                wrap_cnt_d = wrap_cnt_q + 1'b1;
              end
            end else begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          // Unused encoding: recover to idle
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
    end
  end

  // Status outputs
  always_comb begin
    bus.count    = count_q;
    bus.busy     = running;
    bus.tc       = at_end;
    bus.done     = (state_q == StDone);
    bus.err      = err_q;
    bus.wrap_cnt = wrap_cnt_q;
  end

  // The count must stay inside the latched range while running
  assert property (@(posedge clk) disable iff (rst)
    running |-> ((count_q >= lo_q) && (count_q <= hi_q)));

  // busy and done are mutually exclusive
  assert property (@(posedge clk) disable iff (rst) !(bus.busy && bus.done));

endmodule

// File: tb/tb_range_counter_param.sv
module tb_range_counter_param;

  logic       clk = 1'b0;
  logic       rst_r = 1'b1;
  logic       start_r = 1'b0;
  logic       stop_r = 1'b0;
  logic       en_r = 1'b0;
  logic       dir_r = 1'b0;
  logic       wrap_r = 1'b0;
  logic [7:0] lo_r = 8'd0;
  logic [7:0] hi_r = 8'd0;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (plain integers)
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int m_count = 0;
  int m_lo = 0;
  int m_hi = 0;
  int m_dir = 0;
  int m_wrap = 0;
  int m_wcnt = 0;   // unbounded; saturation applied at compare time
  int m_err = 0;

  always #5 clk = ~clk;

  range_counter_param_if #(.WIDTH(8), .WRAPW(8)) if0 ();
  range_counter_param_if #(.WIDTH(8), .WRAPW(2)) if1 ();

  assign if0.start = start_r;
  assign if0.stop = stop_r;
  assign if0.en = en_r;
  assign if0.dir_down = dir_r;
  assign if0.mode_wrap = wrap_r;
  assign if0.lo = lo_r;
  assign if0.hi = hi_r;
  assign if1.start = start_r;
  assign if1.stop = stop_r;
  assign if1.en = en_r;
  assign if1.dir_down = dir_r;
  assign if1.mode_wrap = wrap_r;
  assign if1.lo = lo_r;
  assign if1.hi = hi_r;

  range_counter_param #(.WIDTH(8), .WRAPW(8)) u_dut (
    .clk (clk),
    .rst (rst_r),
    .bus (if0)
  );

  range_counter_param #(.WIDTH(8), .WRAPW(2)) u_sat (
    .clk (clk),
    .rst (rst_r),
    .bus (if1)
  );

  typedef struct {
    bit rst;
    bit start;
    bit stop;
    bit en;
    bit dir;
    bit wrap;
    int lo;
    int hi;
    int e_count;
    bit e_busy;
    bit e_tc;
    bit e_done;
    bit e_err;
    int e_w;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    int bv;
    int ev;
    m_err = 0;
    if (rst_r) begin
      m_state = 0; m_count = 0; m_wcnt = 0;
      m_lo = 0; m_hi = 0; m_dir = 0; m_wrap = 0;
    end else if (stop_r) begin
      m_state = 0;
    end else if (start_r) begin
      if (lo_r <= hi_r) begin
        m_lo = int'(lo_r); m_hi = int'(hi_r); m_dir = int'(dir_r); m_wrap = int'(wrap_r);
        m_count = dir_r ? m_hi : m_lo;
        m_wcnt = 0;
        m_state = 1;
      end else begin
        m_err = 1;
      end
    end else if (m_state == 1 && en_r) begin
      bv = m_dir ? m_hi : m_lo;
      ev = m_dir ? m_lo : m_hi;
      if (m_count != ev) m_count = m_dir ? m_count - 1 : m_count + 1;
      else if (m_wrap != 0) begin m_count = bv; m_wcnt++; end
      else m_state = 2;
    end
  endtask

  task automatic compare_model();
    int m_tc;
    m_tc = (m_state == 1 && m_count == (m_dir ? m_lo : m_hi)) ? 1 : 0;
    check("count", int'(if0.count), m_count);
    check("busy", int'(if0.busy), (m_state == 1) ? 1 : 0);
    check("tc", int'(if0.tc), m_tc);
    check("done", int'(if0.done), (m_state == 2) ? 1 : 0);
    check("err", int'(if0.err), m_err);
    check("wrap_cnt", int'(if0.wrap_cnt), sat(m_wcnt, 255));
    check("sat_count", int'(if1.count), m_count);
    check("sat_wrap_cnt", int'(if1.wrap_cnt), sat(m_wcnt, 3));
  endtask

  // One clock: model follows the edge, DUT outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input bit rs, input bit st, input bit sp, input bit e, input bit d,
                       input bit w, input int l, input int h);
    rst_r = rs; start_r = st; stop_r = sp; en_r = e; dir_r = d; wrap_r = w;
    lo_r = 8'(l); hi_r = 8'(h);
  endtask

  initial begin
    //               rst st sp en d w lo hi  cnt busy tc done err w
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 1, 1, 3, 6,   6, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 0, 0,   5, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 0,   4, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 0,   3, 1, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0,   6, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 1, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 1, 0, 0, 9, 2,   5, 1, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 0, 0, 0,   5, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 7, 7,   7, 1, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 0,   7, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 0, 0, 0,   7, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 1, 1, 1, 0, 0, 1, 2,   7, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 9, 2,   7, 0, 0, 0, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0};

    #2;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].en, tbl[i].dir, tbl[i].wrap,
            tbl[i].lo, tbl[i].hi);
      step();
      check($sformatf("vec%0d_count", i), int'(if0.count), tbl[i].e_count);
      check($sformatf("vec%0d_busy", i), int'(if0.busy), int'(tbl[i].e_busy));
      check($sformatf("vec%0d_tc", i), int'(if0.tc), int'(tbl[i].e_tc));
      check($sformatf("vec%0d_done", i), int'(if0.done), int'(tbl[i].e_done));
      check($sformatf("vec%0d_err", i), int'(if0.err), int'(tbl[i].e_err));
      check($sformatf("vec%0d_wrap", i), int'(if0.wrap_cnt), tbl[i].e_w);
    end

    // Up one-shot 5..67 with continuous enable
    drive(0, 1, 0, 1, 0, 0, 5, 67);
    step();
    check("t1_begin", int'(if0.count), 5);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 62; k++) step();
    check("t1_end", int'(if0.count), 67);
    check("t1_tc", int'(if0.tc), 1);
    step();
    check("t1_done", int'(if0.done), 1);
    for (int k = 0; k < 5; k++) step();
    check("t1_hold", int'(if0.count), 67);

    // Down wrap 6..3; narrow wrap counter must stick at 3
    drive(0, 1, 0, 1, 1, 1, 3, 6);
    step();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 24; k++) step();
    check("t2_wrap8", int'(if0.wrap_cnt), 6);
    check("t2_wrap2", int'(if1.wrap_cnt), 3);
    check("t2_count", int'(if0.count), 6);

    // Enable toggling, 0..4 up one-shot: done after five enabled cycles
    drive(0, 1, 0, 0, 0, 0, 0, 4);
    step();
    for (int k = 0; k < 10; k++) begin
      en_r = (k % 2 == 0);
      start_r = 1'b0;
      step();
    end
    check("t3_count", int'(if0.count), 4);
    check("t3_done", int'(if0.done), 1);

    // Full range: no arithmetic wrap past 255
    drive(0, 1, 0, 1, 0, 0, 0, 255);
    step();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 255; k++) step();
    check("t5_top", int'(if0.count), 255);
    check("t5_tc", int'(if0.tc), 1);
    step();
    step();
    check("t5_done", int'(if0.done), 1);
    check("t5_hold", int'(if0.count), 255);

    // Reset mid-run at count 40, then clean restart
    drive(0, 1, 0, 1, 0, 0, 0, 100);
    step();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 40; k++) step();
    check("t6_count40", int'(if0.count), 40);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    step();
    check("t6_rst_count", int'(if0.count), 0);
    check("t6_rst_busy", int'(if0.busy), 0);
    drive(0, 1, 0, 1, 0, 0, 10, 20);
    step();
    check("t6_restart", int'(if0.count), 10);
    check("t6_restart_busy", int'(if0.busy), 1);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int l;
      int h;
      l = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) h = int'($urandom_range(0, 255));
      else begin
        h = l + int'($urandom_range(0, 7));
        if (h > 255) h = 255;
      end
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l, h);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
